// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmitter
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_parity.sv
// rtl/uart_tx_parity.sv - combinational even/odd parity of a data word
module uart_tx_parity
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_par_typ,
  output logic                  o_parity
);

  assign o_parity = (i_par_typ == PAR_ODD) ? ~^i_data : ^i_data;

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmit serializer with one-entry holding register
// Parity bit support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_valid,
  output logic                  o_ready,
  input  logic                  i_par_en,
  input  logic                  i_par_typ,
  output logic                  o_tx_out,
  output logic                  o_busy
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  uart_state_e           state_q, state_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  par_en_load;
  logic                  par_calc;
  logic                  load;

`ifdef UART_TX_PARITY_EN
  uart_tx_parity #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .i_data   (hold_q),
    .i_par_typ(i_par_typ),
    .o_parity (par_calc)
  );
  assign par_en_load = i_par_en;
`else
  logic unused_par;
  assign unused_par  = i_par_en ^ i_par_typ;
  assign par_calc    = 1'b0;
  assign par_en_load = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    par_en_d    = par_en_q;
    par_bit_d   = par_bit_q;
    load        = 1'b0;

    if (i_data_valid && !hold_full_q) begin
      hold_d      = i_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        load = hold_full_q;
      end
      START: begin
        state_d = DATA;
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1;
        cnt_d   = '0;
      end
      DATA: begin
        if (cnt_q == LAST_BIT) begin
          cnt_d = '0;
          if (par_en_q) begin
            state_d = PARITY;
            tx_d    = par_bit_q;
          end else begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
        end else begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      PARITY: begin
        state_d = STOP;
        tx_d    = 1'b1;
      end
      STOP: begin
        tx_d = 1'b1;
        if (hold_full_q) begin
          load = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Load only happens with the holding register full, so it never races a capture.
    if (load) begin
      state_d     = START;
      tx_d        = 1'b0;
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      par_en_d    = par_en_load;
      par_bit_d   = par_calc;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      par_en_q    <= 1'b0;
      par_bit_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      par_en_q    <= par_en_d;
      par_bit_q   <= par_bit_d;
    end
  end

  assign o_tx_out = tx_q;
  assign o_busy   = busy_q;
  assign o_ready  = !hold_full_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic       ready;
  logic       tx;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx #(.DATA_WIDTH(8)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_data      (data),
    .i_data_valid(valid),
    .o_ready     (ready),
    .i_par_en    (par_en),
    .i_par_typ   (par_typ),
    .o_tx_out    (tx),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic present_word(input logic [7:0] w);
    @(negedge clk);
    data  = w;
    valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx got %b want 1", tx); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle got tx=%b busy=%b want tx=1 busy=0", tx, busy);
    end
  endtask

  task automatic test_frame_a5;
    logic exp_line [0:9];
    exp_line = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    par_en = 1'b0;
    present_word(8'hA5);
    n_checks++;
    if (ready !== 1'b0 || tx !== 1'b1) begin
      n_fail++; $display("FAIL a5_latency got ready=%b tx=%b want ready=0 tx=1", ready, tx);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (tx !== exp_line[k] || busy !== 1'b1) begin
        n_fail++; $display("FAIL a5_bit%0d got tx=%b busy=%b want tx=%b busy=1", k, tx, busy, exp_line[k]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || ready !== 1'b1) begin
      n_fail++; $display("FAIL a5_end got tx=%b busy=%b ready=%b want 1/0/1", tx, busy, ready);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity(input logic typ, input logic exp_par);
    logic exp_line [0:10];
    exp_line = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_line[9] = exp_par;
    par_en  = 1'b1;
    par_typ = typ;
    present_word(8'hA5);
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      n_checks++;
      if (tx !== exp_line[k] || busy !== 1'b1) begin
        n_fail++; $display("FAIL par%0d_bit%0d got tx=%b busy=%b want tx=%b busy=1", typ, k, tx, busy, exp_line[k]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL par%0d_end got tx=%b busy=%b want 1/0", typ, tx, busy);
    end
    par_en  = 1'b0;
    par_typ = 1'b0;
  endtask
`else
  task automatic test_parity_disabled;
    logic exp_line [0:9];
    exp_line = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    par_en  = 1'b1;
    par_typ = 1'b0;
    present_word(8'h3C);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 4) par_typ = 1'b1;
      n_checks++;
      if (tx !== exp_line[k] || busy !== 1'b1) begin
        n_fail++; $display("FAIL nopar_bit%0d got tx=%b busy=%b want tx=%b busy=1", k, tx, busy, exp_line[k]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL nopar_end got tx=%b busy=%b want 1/0", tx, busy);
    end
    par_en  = 1'b0;
    par_typ = 1'b0;
  endtask
`endif

  task automatic test_back_to_back;
    logic exp_tx;
    par_en = 1'b0;
    present_word(8'h00);
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      if (k == 2) begin
        n_checks++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b want 1", ready); end
        data  = 8'hFF;
        valid = 1'b1;
      end
      if (k == 3) begin
        valid = 1'b0;
        n_checks++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL b2b_held got ready=%b want 0", ready); end
      end
      if (k <= 9)       exp_tx = 1'b0;
      else if (k == 10) exp_tx = 1'b1;
      else if (k == 11) exp_tx = 1'b0;
      else              exp_tx = 1'b1;
      n_checks++;
      if (tx !== exp_tx || busy !== (k <= 20)) begin
        n_fail++; $display("FAIL b2b_cycle%0d got tx=%b busy=%b want tx=%b busy=%b", k, tx, busy, exp_tx, (k <= 20));
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    par_en = 1'b0;
    present_word(8'h00);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 2) begin
        data  = 8'hFF;
        valid = 1'b1;
      end
      if (k == 3) valid = 1'b0;
    end
    n_checks++;
    if (tx !== 1'b0 || ready !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_pre got tx=%b ready=%b want tx=0 ready=0", tx, ready);
    end
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_async got tx=%b busy=%b ready=%b want 1/0/1", tx, busy, ready);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      n_checks++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
        n_fail++; $display("FAIL rstmid_idle%0d got tx=%b busy=%b want 1/0", k, tx, busy);
      end
    end
  endtask

  initial begin
    test_reset;
    test_frame_a5;
`ifdef UART_TX_PARITY_EN
    test_parity(1'b0, 1'b0);
    test_parity(1'b1, 1'b1);
`else
    test_parity_disabled;
`endif
    test_back_to_back;
    test_reset_mid_frame;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
